// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Fetch-2 redirect request (branch-predict correction)
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            is_predict;
  } wr_pc_req_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CMT  = 2'd1,
    EX   = 2'd2,
    IF2  = 2'd3
  } redir_src_e;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    IDLE = 2'd2
  } fetch_state_e;

  // Per-stage flush request, youngest stage first
  typedef struct packed {
    logic if1;
    logic if2;
    logic id;
    logic ex;
  } flush_vec_t;

  // A redirect flushes every stage younger than the stage that raised it
  function automatic flush_vec_t flush_mask(input redir_src_e src);
    flush_vec_t m;
    m = '0;
    case (src)
      CMT:     m = '{if1: 1'b1, if2: 1'b1, id: 1'b1, ex: 1'b1};
      EX:      m = '{if1: 1'b1, if2: 1'b1, id: 1'b1, ex: 1'b0};
      IF2:     m = '{if1: 1'b1, if2: 1'b0, id: 1'b0, ex: 1'b0};
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_arb.sv
// Combinational priority arbiter: commit > execute > fetch-2.
module redir_arb
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic            cmt_en_i,
  input  logic            low_en_i,
  input  logic            cmt_valid_i,
  input  logic [XLEN-1:0] cmt_pc_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  wr_pc_req_t      if2_req_i,
  output redir_src_e      win_src_o,
  output logic [XLEN-1:0] win_pc_o,
  output flush_vec_t      flush_o
);

  // The predict flag only matters to fetch-2 bookkeeping, not to arbitration
  logic unused_if2_predict;
  assign unused_if2_predict = if2_req_i.is_predict;

  // Pick a single winner; execute and fetch-2 are only eligible when low_en_i
  always_comb begin
    win_src_o = NONE;
    win_pc_o  = '0;
    if (cmt_en_i && cmt_valid_i) begin
      win_src_o = CMT;
      win_pc_o  = cmt_pc_i;
    end else if (low_en_i && ex_valid_i) begin
      win_src_o = EX;
      win_pc_o  = ex_pc_i;
    end else if (low_en_i && if2_req_i.valid) begin
      win_src_o = IF2;
      win_pc_o  = if2_req_i.pc;
    end
    flush_o = flush_mask(win_src_o);
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: owns the fetch PC, arbitrates redirects, sequences boot/idle.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmt_redir_valid,
  input  logic [31:0] cmt_redir_pc,
  input  logic        cmt_idle,
  input  logic        int_pending,
  input  logic        ex_redir_valid,
  input  logic [31:0] ex_redir_pc,
  input  wr_pc_req_t  if2_req,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic        icache_ready,
  input  logic        fetch1_rdy_in,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] next_pc,
  output logic        next_is_predict,
  output logic        flush_if1,
  output logic        flush_if2,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [31:0] perf_cmt,
  output logic [31:0] perf_ex,
  output logic [31:0] perf_if2
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] perf_cmt_q, perf_cmt_d;
  logic [XLEN-1:0] perf_ex_q, perf_ex_d;
  logic [XLEN-1:0] perf_if2_q, perf_if2_d;

  redir_src_e      win_src;
  logic [XLEN-1:0] win_pc;
  flush_vec_t      flush;
  logic            in_run;
  logic            in_idle;
  logic            fire;

  assign in_run  = (state_q == RUN);
  assign in_idle = (state_q == IDLE);

  // Commit is honoured in RUN and IDLE (wake); execute/fetch-2 only in RUN
  redir_arb u_arb (
    .cmt_en_i    (in_run | in_idle),
    .low_en_i    (in_run),
    .cmt_valid_i (cmt_redir_valid),
    .cmt_pc_i    (cmt_redir_pc),
    .ex_valid_i  (ex_redir_valid),
    .ex_pc_i     (ex_redir_pc),
    .if2_req_i   (if2_req),
    .win_src_o   (win_src),
    .win_pc_o    (win_pc),
    .flush_o     (flush)
  );

  // Fetch-1 handshake and sequential successor prediction
  assign fetch_valid     = in_run & icache_ready & (win_src == NONE);
  assign fire            = fetch_valid & fetch1_rdy_in;
  assign fetch_pc        = pc_q;
  assign next_pc         = btb_hit ? btb_target : XLEN'(pc_q + PC_STEP);
  assign next_is_predict = btb_hit;

  assign flush_if1 = flush.if1;
  assign flush_if2 = flush.if2;
  assign flush_id  = flush.id;
  assign flush_ex  = flush.ex;

  assign perf_cmt = perf_cmt_q;
  assign perf_ex  = perf_ex_q;
  assign perf_if2 = perf_if2_q;

  // Next state, next PC and counter updates
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    perf_cmt_d = perf_cmt_q;
    perf_ex_d  = perf_ex_q;
    perf_if2_d = perf_if2_q;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (win_src != NONE) begin
          pc_d = win_pc;
          if ((win_src == CMT) && cmt_idle) state_d = IDLE;
        end else if (fire) begin
          pc_d = next_pc;
        end
      end
      IDLE: begin
        if (win_src == CMT) begin
          pc_d    = win_pc;
          state_d = RUN;
        end else if (int_pending) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    case (win_src)
      CMT:     perf_cmt_d = XLEN'(perf_cmt_q + 32'd1);
      EX:      perf_ex_d  = XLEN'(perf_ex_q + 32'd1);
      IF2:     perf_if2_d = XLEN'(perf_if2_q + 32'd1);
      default: ;
    endcase
  end

  // State, PC and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      perf_cmt_q <= '0;
      perf_ex_q  <= '0;
      perf_if2_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      perf_cmt_q <= perf_cmt_d;
      perf_ex_q  <= perf_ex_d;
      perf_if2_q <= perf_if2_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk;
  logic        rst;
  logic        cmt_redir_valid;
  logic [31:0] cmt_redir_pc;
  logic        cmt_idle;
  logic        int_pending;
  logic        ex_redir_valid;
  logic [31:0] ex_redir_pc;
  wr_pc_req_t  if2_req;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic        icache_ready;
  logic        fetch1_rdy_in;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] next_pc;
  logic        next_is_predict;
  logic        flush_if1, flush_if2, flush_id, flush_ex;
  logic [31:0] perf_cmt, perf_ex, perf_if2;

  fetch_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmt_redir_valid (cmt_redir_valid),
    .cmt_redir_pc    (cmt_redir_pc),
    .cmt_idle        (cmt_idle),
    .int_pending     (int_pending),
    .ex_redir_valid  (ex_redir_valid),
    .ex_redir_pc     (ex_redir_pc),
    .if2_req         (if2_req),
    .btb_hit         (btb_hit),
    .btb_target      (btb_target),
    .icache_ready    (icache_ready),
    .fetch1_rdy_in   (fetch1_rdy_in),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .next_pc         (next_pc),
    .next_is_predict (next_is_predict),
    .flush_if1       (flush_if1),
    .flush_if2       (flush_if2),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .perf_cmt        (perf_cmt),
    .perf_ex         (perf_ex),
    .perf_if2        (perf_if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        npred;
    logic [3:0]  fl;
    logic [31:0] c_cmt;
    logic [31:0] c_ex;
    logic [31:0] c_if2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: 0 = boot, 1 = run, 2 = idle
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_cnt_cmt, m_cnt_ex, m_cnt_if2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    cmt_redir_valid = 1'b0;
    cmt_redir_pc    = '0;
    cmt_idle        = 1'b0;
    int_pending     = 1'b0;
    ex_redir_valid  = 1'b0;
    ex_redir_pc     = '0;
    if2_req         = '0;
    btb_hit         = 1'b0;
    btb_target      = '0;
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_pc      = RST_PC;
    m_cnt_cmt = '0;
    m_cnt_ex  = '0;
    m_cnt_if2 = '0;
  endtask

  // 0 none, 1 commit, 2 execute, 3 fetch-2
  function automatic int model_winner();
    if (cmt_redir_valid && (m_state == 1 || m_state == 2)) return 1;
    if (ex_redir_valid && m_state == 1) return 2;
    if (if2_req.valid && m_state == 1) return 3;
    return 0;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    int   w;
    w       = model_winner();
    e.fv    = (m_state == 1) && icache_ready && (w == 0);
    e.pc    = m_pc;
    e.npc   = btb_hit ? btb_target : m_pc + 32'd4;
    e.npred = btb_hit;
    case (w)
      1:       e.fl = 4'b1111;
      2:       e.fl = 4'b1110;
      3:       e.fl = 4'b1000;
      default: e.fl = 4'b0000;
    endcase
    e.c_cmt = m_cnt_cmt;
    e.c_ex  = m_cnt_ex;
    e.c_if2 = m_cnt_if2;
    return e;
  endfunction

  task automatic model_edge();
    int   w;
    logic fv;
    w  = model_winner();
    fv = (m_state == 1) && icache_ready && (w == 0);
    if (w == 1) begin
      m_pc = cmt_redir_pc;
      m_cnt_cmt++;
      m_state = (m_state == 1 && cmt_idle) ? 2 : 1;
    end else if (w == 2) begin
      m_pc = ex_redir_pc;
      m_cnt_ex++;
    end else if (w == 3) begin
      m_pc = if2_req.pc;
      m_cnt_if2++;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 2) begin
      if (int_pending) m_state = 1;
    end else if (fv && fetch1_rdy_in) begin
      m_pc = btb_hit ? btb_target : m_pc + 32'd4;
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
      check("fetch_pc", fetch_pc, e.pc);
      check("next_pc", next_pc, e.npc);
      check("next_is_predict", 32'(next_is_predict), 32'(e.npred));
      check("flushes", 32'({flush_if1, flush_if2, flush_id, flush_ex}), 32'(e.fl));
      check("perf_cmt", perf_cmt, e.c_cmt);
      check("perf_ex", perf_ex, e.c_ex);
      check("perf_if2", perf_if2, e.c_if2);
    end
  endtask

  // One cycle: inputs already driven; sample at negedge, advance model at posedge
  task automatic step();
    sb.push_back(model_expect());
    @(negedge clk);
    compare_front();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Assert reset between edges and check the values appear without a clock
  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    #1;
    sb.push_back(model_expect());
    compare_front();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst           = 1'b1;
    icache_ready  = 1'b0;
    fetch1_rdy_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(model_expect());
    compare_front();
    rst = 1'b0;

    // Boot and sequential fetch
    icache_ready  = 1'b1;
    fetch1_rdy_in = 1'b1;
    repeat (4) step();

    // All three sources at once: commit wins
    cmt_redir_valid = 1'b1; cmt_redir_pc = 32'h1c00_8000;
    ex_redir_valid  = 1'b1; ex_redir_pc  = 32'h1c00_0100;
    if2_req = '{valid: 1'b1, pc: 32'h1c00_0200, is_predict: 1'b1};
    step();
    clear_inputs();
    step();

    // Fetch-2 alone with fetch-1 stalled
    fetch1_rdy_in = 1'b0;
    if2_req = '{valid: 1'b1, pc: 32'h1c00_0040, is_predict: 1'b0};
    step();
    clear_inputs();
    fetch1_rdy_in = 1'b1;
    step();

    // BTB hit at fire
    btb_hit = 1'b1; btb_target = 32'h1c00_0400;
    step();
    clear_inputs();
    step();

    // icache not ready: PC holds
    icache_ready = 1'b0;
    step(); step();
    icache_ready = 1'b1;

    // Execute alone
    ex_redir_valid = 1'b1; ex_redir_pc = 32'h1c00_0c00;
    step();
    clear_inputs();
    step();

    // Enter idle, ignore execute, wake on interrupt
    cmt_redir_valid = 1'b1; cmt_idle = 1'b1; cmt_redir_pc = 32'h1c00_0010;
    step();
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      ex_redir_valid = (i == 4);
      ex_redir_pc    = 32'h1c00_0ee0;
      if2_req.valid  = (i == 6);
      if2_req.pc     = 32'h1c00_0ff0;
      step();
    end
    clear_inputs();
    int_pending = 1'b1;
    step();
    clear_inputs();
    step(); step();

    // Idle again, commit wakes it and beats interrupt; cmt_idle cannot re-enter
    cmt_redir_valid = 1'b1; cmt_idle = 1'b1; cmt_redir_pc = 32'h1c00_0010;
    step();
    clear_inputs();
    step(); step();
    cmt_redir_valid = 1'b1; cmt_idle = 1'b1; cmt_redir_pc = 32'h1c00_0020;
    int_pending = 1'b1;
    step();
    clear_inputs();
    step(); step();

    // Reset mid-idle
    cmt_redir_valid = 1'b1; cmt_idle = 1'b1; cmt_redir_pc = 32'h1c00_0030;
    step();
    clear_inputs();
    step(); step();
    async_reset();
    step(); step(); step();

    // Wrap of the sequential PC
    ex_redir_valid = 1'b1; ex_redir_pc = 32'hffff_fffc;
    step();
    clear_inputs();
    step(); step(); step();

    // Reset with ffff_fffc about to fire
    ex_redir_valid = 1'b1; ex_redir_pc = 32'hffff_fffc;
    step();
    clear_inputs();
    async_reset();
    step(); step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cmt_redir_valid = ($urandom_range(0, 7) == 0);
      cmt_idle        = ($urandom_range(0, 3) == 0);
      cmt_redir_pc    = {$urandom()} & 32'hffff_fffc;
      int_pending     = ($urandom_range(0, 3) == 0);
      ex_redir_valid  = ($urandom_range(0, 7) == 0);
      ex_redir_pc     = {$urandom()} & 32'hffff_fffc;
      if2_req.valid   = ($urandom_range(0, 5) == 0);
      if2_req.pc      = {$urandom()} & 32'hffff_fffc;
      if2_req.is_predict = 1'($urandom_range(0, 1));
      btb_hit         = ($urandom_range(0, 3) == 0);
      btb_target      = {$urandom()} & 32'hffff_fffc;
      icache_ready    = ($urandom_range(0, 3) != 0);
      fetch1_rdy_in   = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Front-end PC sequencer that owns the fetch PC register and feeds the fetch-1 stage. It arbitrates PC redirects from three sources: commit (exception, ertn, refetch, idle), execute (branch mispredict) and fetch-2 (branch-predict correction via `wr_pc_req_t`). It generates per-stage flushes for the winning redirect, handles the boot and idle-halt sequencing, and keeps per-source redirect counters for performance monitoring.

## Interface
Parameters:
- `RESET_PC`, default 32'h1c00_0000: fetch PC loaded on reset.

Ports:
- `clk`  in  1  sole clock, all state on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmt_redir_valid`  in  1  commit redirect (exception, ertn, refetch).
- `cmt_redir_pc`  in  32  commit redirect target.
- `cmt_idle`  in  1  idle instruction committed. Qualified by `cmt_redir_valid`; target is `cmt_redir_pc`.
- `int_pending`  in  1  interrupt pending, used only to wake from idle.
- `ex_redir_valid`  in  1  execute branch-mispredict redirect.
- `ex_redir_pc`  in  32  execute redirect target.
- `if2_req`  in  `wr_pc_req_t`  fetch-2 redirect request (valid, pc, is_predict).
- `btb_hit`  in  1  BTB hit for current `fetch_pc`.
- `btb_target`  in  32  BTB predicted target.
- `icache_ready`  in  1  icache can accept a lookup.
- `fetch1_rdy_in`  in  1  fetch-1 accepts a PC this cycle.
- `fetch_valid`  out  1  `fetch_pc` valid.
- `fetch_pc`  out  32  current fetch PC.
- `next_pc`  out  32  predicted successor of `fetch_pc`.
- `next_is_predict`  out  1  `next_pc` came from the BTB.
- `flush_if1`, `flush_if2`, `flush_id`, `flush_ex`  out  1 each  stage flushes.
- `perf_cmt`, `perf_ex`, `perf_if2`  out  32 each  accepted-redirect counters.

## Operation
- State machine with states BOOT, RUN, IDLE.
  - Reset → BOOT. `pc_r` = `RESET_PC`, counters = 0.
  - BOOT → RUN unconditionally on the next edge.
- Redirect priority is commit > execute > fetch-2. Exactly one winner per cycle; losers are dropped and not counted.
- Flushes are combinational in the request cycle and gated by the winner:
  - commit: all four flushes.
  - execute: `if1`, `if2`, `id`.
  - fetch-2: `if1` only.
  - A losing fetch-2 request produces no flush of its own.
- `fetch_valid` = (state == RUN) & `icache_ready` & no redirect winner this cycle.
- Fire = `fetch_valid` & `fetch1_rdy_in`.
- `next_pc` = `btb_hit` ? `btb_target` : `fetch_pc` + 4, using 32-bit wrapping add. `next_is_predict` = `btb_hit`.
- In RUN:
  - A winner loads `pc_r` with the winner's target. This overrides fire.
  - If the winner is commit with `cmt_idle` = 1, go to IDLE.
  - Otherwise, fire loads `pc_r` with `next_pc`.
  - Otherwise, `pc_r` holds.
- In IDLE:
  - `fetch_valid` = 0. `pc_r` holds the idle target.
  - `int_pending` → RUN.
  - `cmt_redir_valid` → load target and go to RUN. This takes priority over `int_pending`, and no `cmt_idle` re-entry is allowed.
  - Execute and fetch-2 requests are ignored and produce no flush.
- In BOOT, all requests are ignored and all flushes are 0.
- Counters increment by 1 on each accepted winner of their source and wrap at 2^32.

## Timing
- Reset values: `fetch_valid` = 0, `fetch_pc` = `RESET_PC`, `next_pc` = `RESET_PC` + 4 (or `btb_target` if `btb_hit`), flushes = 0, counters = 0.
- Redirect in cycle N:
  - flushes are high in cycle N only;
  - `fetch_pc` equals the target in N+1;
  - `fetch_valid` can be high in N+1 (redirect-to-fetch latency 1).
- PC advance: fire in N gives a new `fetch_pc` in N+1. Without fire, `fetch_pc` is stable and `fetch_valid` may toggle with `icache_ready`.
- IDLE wake: `int_pending` in N gives `fetch_valid` possible in N+1.
- `rst` asserted in any state is immediate (asynchronous) → BOOT values.

## Structure
- Shared package holds:
  - `wr_pc_req_t` (existing);
  - the new `redir_src_e` {NONE, CMT, EX, IF2};
  - `fetch_state_e` {BOOT, RUN, IDLE};
  - the `RESET_PC` default constant.
- One sub-module: `redir_arb`. It is a combinational priority arbiter that outputs winner source, target and flush vector, and is reused for verification of flush masks.

## Test plan
- Reset, then `icache_ready` = `fetch1_rdy_in` = 1, no BTB hit → `fetch_valid` rises cycle 2; `fetch_pc` goes 1c000000, 1c000004, 1c000008.
- Same-cycle `cmt_redir_pc` = 1c008000, `ex_redir_pc` = 1c000100, `if2_req.pc` = 1c000200 → all four flushes high for one cycle; next `fetch_pc` = 1c008000; `perf_cmt` = 1, `perf_ex` = `perf_if2` = 0.
- `if2_req` valid with pc 1c000040 alone while `fetch1_rdy_in` = 0 → only `flush_if1`; `fetch_pc` = 1c000040 next cycle; `fetch_valid` low in the request cycle.
- `btb_hit` = 1, `btb_target` = 1c000400 at fire → `next_is_predict` = 1; `fetch_pc` becomes 1c000400.
- `cmt_idle` with target 1c000010 → IDLE with `fetch_valid` = 0 for 10 cycles; an `ex_redir_valid` there gives no flush; `int_pending` → `fetch_pc` = 1c000010 and valid the next cycle.
- `rst` pulsed mid-IDLE and with `fetch_pc` = ffff_fffc at fire → BOOT values immediately; separately, the wrap case gives `next_pc` = 0000_0000.
